// File: rtl/ascon_pkg.sv
// Shared definitions for the ASCON permutation engine: round counts, encodings,
// FSM states and the round-constant / rotation helpers.
package ascon_pkg;

   localparam int unsigned ROUNDS_P12 = 12;
   localparam int unsigned ROUNDS_P8  = 8;
   localparam int unsigned ROUNDS_P6  = 6;

   typedef enum logic [1:0] {
      SEL_P12  = 2'b00,
      SEL_P8   = 2'b01,
      SEL_P6   = 2'b10,
      SEL_RSVD = 2'b11
   } rounds_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Five 64-bit words, element 0 is x0.
   typedef logic [4:0][63:0] ascon_state_t;

   // rc(i) = ((15 - i) << 4) | i; for a 4-bit i the high nibble is simply ~i.
   function automatic logic [7:0] rc(input logic [3:0] i);
      return {~i, i};
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // First round index for a job: 12 - n; the reserved encoding runs all 12.
   function automatic logic [3:0] start_idx(input logic [1:0] sel);
      case (sel)
         SEL_P8:  return 4'(ROUNDS_P12 - ROUNDS_P8);
         SEL_P6:  return 4'(ROUNDS_P12 - ROUNDS_P6);
         default: return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ascon_permutation_1p.sv
// One combinational ASCON round: constant addition, bitsliced 5-bit S-box and
// linear diffusion layer.
module ascon_permutation_1p
   import ascon_pkg::*;
(
   input  logic [63:0] x0_i,
   input  logic [63:0] x1_i,
   input  logic [63:0] x2_i,
   input  logic [63:0] x3_i,
   input  logic [63:0] x4_i,
   input  logic [7:0]  rc_i,
   output logic [63:0] x0_o,
   output logic [63:0] x1_o,
   output logic [63:0] x2_o,
   output logic [63:0] x3_o,
   output logic [63:0] x4_o
);

   logic [63:0] a0, a1, a2, a3, a4;
   logic [63:0] b0, b1, b2, b3, b4;
   logic [63:0] s0, s1, s2, s3, s4;

   assign a0 = x0_i ^ x4_i;
   assign a1 = x1_i;
   assign a2 = x2_i ^ {56'd0, rc_i} ^ x1_i;
   assign a3 = x3_i;
   assign a4 = x4_i ^ x3_i;

   // Chi-like core of the S-box.
   assign b0 = a0 ^ (~a1 & a2);
   assign b1 = a1 ^ (~a2 & a3);
   assign b2 = a2 ^ (~a3 & a4);
   assign b3 = a3 ^ (~a4 & a0);
   assign b4 = a4 ^ (~a0 & a1);

   assign s0 = b0 ^ b4;
   assign s1 = b1 ^ b0;
   assign s2 = ~b2;
   assign s3 = b3 ^ b2;
   assign s4 = b4;

   assign x0_o = s0 ^ rotr(s0, 19) ^ rotr(s0, 28);
   assign x1_o = s1 ^ rotr(s1, 61) ^ rotr(s1, 39);
   assign x2_o = s2 ^ rotr(s2, 1)  ^ rotr(s2, 6);
   assign x3_o = s3 ^ rotr(s3, 10) ^ rotr(s3, 17);
   assign x4_o = s4 ^ rotr(s4, 7)  ^ rotr(s4, 41);

endmodule

// File: rtl/ascon_perm_engine.sv
// Iterative ASCON permutation engine (p12/p8/p6) with valid/ready handshakes,
// applying ROUNDS_PER_CYCLE chained rounds per clock.
module ascon_perm_engine
   import ascon_pkg::*;
#(
   parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  rounds_sel,
   input  logic [63:0] x0_i,
   input  logic [63:0] x1_i,
   input  logic [63:0] x2_i,
   input  logic [63:0] x3_i,
   input  logic [63:0] x4_i,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] x0_o,
   output logic [63:0] x1_o,
   output logic [63:0] x2_o,
   output logic [63:0] x3_o,
   output logic [63:0] x4_o,
   output logic        busy
);

   localparam logic [3:0] LAST_START = 4'(ROUNDS_P12 - ROUNDS_PER_CYCLE);

   state_e       state_q, state_d;
   logic [3:0]   idx_q, idx_d;
   ascon_state_t st_q, st_d;

   ascon_state_t chain [ROUNDS_PER_CYCLE + 1];

   assign chain[0] = st_q;

   for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
      ascon_permutation_1p u_round (
         .x0_i (chain[g][0]),
         .x1_i (chain[g][1]),
         .x2_i (chain[g][2]),
         .x3_i (chain[g][3]),
         .x4_i (chain[g][4]),
         .rc_i (rc(4'(idx_q + 4'(g)))),
         .x0_o (chain[g+1][0]),
         .x1_o (chain[g+1][1]),
         .x2_o (chain[g+1][2]),
         .x3_o (chain[g+1][3]),
         .x4_o (chain[g+1][4])
      );
   end

   // NOTE: every _d gets its hold value first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      st_d    = st_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               st_d    = {x4_i, x3_i, x2_i, x1_i, x0_i};
               idx_d   = start_idx(rounds_sel);
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            st_d  = chain[ROUNDS_PER_CYCLE];
            idx_d = idx_q + 4'(ROUNDS_PER_CYCLE);
            if (idx_q >= LAST_START) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: the state words are reset as well, so an aborted job leaves no data
   // on x*_o.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 4'd0;
         st_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         st_q    <= st_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);

   assign x0_o = st_q[0];
   assign x1_o = st_q[1];
   assign x2_o = st_q[2];
   assign x3_o = st_q[3];
   assign x4_o = st_q[4];

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Directed bench for ascon_perm_engine at one and two rounds per cycle,
// checked against a table-driven S-box reference of the ASCON permutation.
module tb_ascon_perm_engine;

   typedef logic [4:0][63:0] st_t;

   typedef struct {
      logic       inst;
      logic [1:0] rs;
      st_t        x;
      int         lat;
   } vec_t;

   localparam logic [4:0] SBOX [0:31] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, in_valid, out_ready, sel;
   logic [1:0] rounds_sel;
   st_t        x_in;

   logic in_ready1, out_valid1, busy1, in_ready2, out_valid2, busy2;
   st_t  xo1, xo2;
   logic in_ready, out_valid, busy;
   st_t  xo;

   int n_vec = 0;
   int n_err = 0;

   ascon_perm_engine #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid & ~sel), .in_ready(in_ready1), .rounds_sel(rounds_sel),
      .x0_i(x_in[0]), .x1_i(x_in[1]), .x2_i(x_in[2]), .x3_i(x_in[3]), .x4_i(x_in[4]),
      .out_valid(out_valid1), .out_ready(out_ready & ~sel),
      .x0_o(xo1[0]), .x1_o(xo1[1]), .x2_o(xo1[2]), .x3_o(xo1[3]), .x4_o(xo1[4]),
      .busy(busy1)
   );

   ascon_perm_engine #(.ROUNDS_PER_CYCLE(2)) u_dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid & sel), .in_ready(in_ready2), .rounds_sel(rounds_sel),
      .x0_i(x_in[0]), .x1_i(x_in[1]), .x2_i(x_in[2]), .x3_i(x_in[3]), .x4_i(x_in[4]),
      .out_valid(out_valid2), .out_ready(out_ready & sel),
      .x0_o(xo2[0]), .x1_o(xo2[1]), .x2_o(xo2[2]), .x3_o(xo2[3]), .x4_o(xo2[4]),
      .busy(busy2)
   );

   assign in_ready  = sel ? in_ready2  : in_ready1;
   assign out_valid = sel ? out_valid2 : out_valid1;
   assign busy      = sel ? busy2      : busy1;
   assign xo        = sel ? xo2        : xo1;

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ror(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // Reference permutation: S-box applied column by column via lookup table.
   function automatic st_t model(input logic [1:0] rs, input st_t s_in);
      st_t        s;
      int         first;
      logic [4:0] col, v;
      s = s_in;
      first = (rs == 2'b01) ? 4 : (rs == 2'b10) ? 6 : 0;
      for (int r = first; r < 12; r++) begin
         s[2] = s[2] ^ (64'hf0 - 64'(15 * r));
         for (int b = 0; b < 64; b++) begin
            col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
            v = SBOX[col];
            s[0][b] = v[4];
            s[1][b] = v[3];
            s[2][b] = v[2];
            s[3][b] = v[1];
            s[4][b] = v[0];
         end
         s[0] = s[0] ^ ror(s[0], 19) ^ ror(s[0], 28);
         s[1] = s[1] ^ ror(s[1], 61) ^ ror(s[1], 39);
         s[2] = s[2] ^ ror(s[2], 1)  ^ ror(s[2], 6);
         s[3] = s[3] ^ ror(s[3], 10) ^ ror(s[3], 17);
         s[4] = s[4] ^ ror(s[4], 7)  ^ ror(s[4], 41);
      end
      return s;
   endfunction

   function automatic st_t rand_state();
      st_t s;
      for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
      return s;
   endfunction

   task automatic wait_ready(input string name);
      int t;
      t = 0;
      while (!in_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      check({name, "_ready"}, in_ready, 1'b1);
   endtask

   // Counts edges from the accept edge until out_valid rises.
   task automatic wait_done(input string name, input int lat);
      int cnt;
      cnt = 0;
      while (!out_valid && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      check({name, "_latency"}, cnt, lat);
   endtask

   task automatic start_job(input logic [1:0] rs, input st_t x);
      rounds_sel = rs;
      x_in       = x;
      in_valid   = 1'b1;
      @(negedge clk);
      in_valid   = 1'b0;
      x_in       = ~x;
   endtask

   task automatic handshake(input string name);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_idle"}, {in_ready, out_valid, busy}, 3'b100);
   endtask

   vec_t vt [8];
   st_t  iv, xa, xb, res, held;
   logic stable;
   int   rises;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
      rounds_sel = 2'b00; x_in = '0;

      iv    = '0;
      iv[0] = 64'h80400c0600000000;
      vt[0] = '{1'b0, 2'b00, iv,           12};
      vt[1] = '{1'b0, 2'b01, rand_state(), 8};
      vt[2] = '{1'b0, 2'b10, rand_state(), 6};
      vt[3] = '{1'b0, 2'b11, rand_state(), 12};
      vt[4] = '{1'b1, 2'b00, vt[0].x,      6};
      vt[5] = '{1'b1, 2'b01, vt[1].x,      4};
      vt[6] = '{1'b1, 2'b10, vt[2].x,      3};
      vt[7] = '{1'b1, 2'b11, vt[3].x,      6};

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_flags1", {in_ready1, out_valid1, busy1}, 3'b100);
      check("reset_state1", xo1, '0);
      check("reset_flags2", {in_ready2, out_valid2, busy2}, 3'b100);
      check("reset_state2", xo2, '0);

      foreach (vt[k]) begin
         sel = vt[k].inst;
         wait_ready("vec");
         start_job(vt[k].rs, vt[k].x);
         check("vec_busy", busy, 1'b1);
         wait_done("vec", vt[k].lat);
         check("vec_state", xo, model(vt[k].rs, vt[k].x));
         handshake("vec");
      end

      // Stall in DONE for 20 cycles, with stray in_valid pulses during RUN.
      sel = 1'b0;
      xa = rand_state();
      wait_ready("stall");
      start_job(2'b00, xa);
      for (int c = 0; c < 6; c++) begin
         rounds_sel = 2'b10;
         in_valid   = c[0];
         out_ready  = ~c[0];
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      wait_done("stall", 6);
      check("stall_state", xo, model(2'b00, xa));
      held = xo;
      stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!out_valid || xo !== held) stable = 1'b0;
      end
      check("stall_stable", stable, 1'b1);
      handshake("stall");

      // Reset in cycle 5 of a p12 job aborts it without an output.
      xa = rand_state();
      wait_ready("abort");
      start_job(2'b00, xa);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_flags", {in_ready, out_valid, busy}, 3'b100);
      check("abort_state", xo, '0);
      rises = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid) rises++;
      end
      check("abort_no_valid", rises, 0);
      start_job(2'b00, xa);
      wait_done("abort_new", 12);
      check("abort_new_state", xo, model(2'b00, xa));
      handshake("abort_new");

      // Back-to-back jobs with in_valid held high.
      xa = rand_state();
      xb = rand_state();
      rounds_sel = 2'b00;
      x_in       = xa;
      in_valid   = 1'b1;
      @(negedge clk);
      wait_done("b2b_a", 12);
      check("b2b_a_state", xo, model(2'b00, xa));
      x_in      = xb;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("b2b_gap", {in_ready, out_valid, busy}, 3'b100);
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b_b_accept", {in_ready, busy}, 2'b01);
      wait_done("b2b_b", 12);
      res = xo;
      check("b2b_b_state", res, model(2'b00, xb));
      handshake("b2b_b");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ascon_perm_engine.md
ASCON_PERM_ENGINE -- requirements
Module: ascon_perm_engine

Interface
- REQ-001: Parameter ROUNDS_PER_CYCLE, default 1; rounds applied per clock; legal values are 1 and 2.
- REQ-002: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-003: rst  input  1  reset, synchronous and active-high.
- REQ-004: in_valid  input  1  a new state and round count are offered.
- REQ-005: in_ready  output  1  engine accepts a job this cycle.
- REQ-006: rounds_sel  input  2  round count: 00 = 12, 01 = 8, 10 = 6, 11 reserved (executes as 12).
- REQ-007: x0_i..x4_i  input  64 each  320-bit input state words.
- REQ-008: out_valid  output  1  permuted state is available.
- REQ-009: out_ready  input  1  consumer accepts the result.
- REQ-010: x0_o..x4_o  output  64 each  permuted state words, registered.
- REQ-011: busy  output  1  high in RUN or DONE.

Function
- REQ-012: FSM states are IDLE, RUN and DONE.
- REQ-013: in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE).
- REQ-014: On IDLE with in_valid: the engine loads x0_i..x4_i into the state register, sets round index i = 12 - n (n from rounds_sel; i.e. 0, 4 or 6), and moves to RUN.
- REQ-015: Each RUN cycle applies ROUNDS_PER_CYCLE consecutive rounds; round i uses constant rc(i) = ((15 - i) << 4) | i in bits [7:0], zero-extended to 64 bits (i = 0 gives 0xf0, i = 11 gives 0x4b).
- REQ-016: i advances by ROUNDS_PER_CYCLE per RUN cycle; when the cycle applying round 11 completes, the state moves to DONE.
- REQ-017: Latency: a job accepted at edge k SHALL give out_valid = 1 after edge k + n/ROUNDS_PER_CYCLE (12/8/6 cycles at ROUNDS_PER_CYCLE = 1).
- REQ-018: In DONE, the outputs and out_valid SHALL hold stable until out_ready = 1; at that edge the state moves to IDLE.
- REQ-019: in_valid outside IDLE SHALL be ignored, with no corruption of the job in flight.
- REQ-020: out_ready outside DONE SHALL be ignored.
- REQ-021: DONE with out_ready, together with in_valid on the same cycle, SHALL return to IDLE without accepting the new job; the job is accepted on the next cycle at the earliest.
- REQ-022: x0_o..x4_o SHALL be the state register contents at all times; their values are meaningful only while out_valid = 1.
- REQ-023: Each round SHALL be bit-exact to the ASCON round: constant XOR on x2, 5-bit S-box, then linear diffusion with rotations (19,28), (61,39), (1,6), (10,17), (7,41).

Reset
- REQ-024: rst = 1 at a rising edge SHALL force IDLE, round index 0, the state register to all zeros, in_ready = 1 (once rst is low), out_valid = 0 and busy = 0.
- REQ-025: rst asserted in RUN or DONE SHALL abort the job with no output handshake; the first acceptance is possible in the cycle after rst deasserts.
- REQ-026: rst SHALL take priority over every handshake input.

Structure
- REQ-027: Shared package ascon_pkg holds: round-constant function rc(i); ROUNDS_P12 = 12, ROUNDS_P8 = 8, ROUNDS_P6 = 6; rounds_sel encodings; FSM state encoding.
- REQ-028: The round logic SHALL be instances of the existing single-round module ascon_permutation_1p: ROUNDS_PER_CYCLE instances chained combinationally, with constants from rc(i) and rc(i+1).
- REQ-029: The engine holds one 320-bit state register, a 4-bit round index and the FSM register; no other storage.

Verification
- REQ-030: rst, then in_valid with rounds_sel = 00, x0 = 0x80400c0600000000 and x1..x4 = 0 -> out_valid after exactly 12 cycles; x0_o..x4_o equal the combinational ascon_permutation_p12 output for the same input.
- REQ-031: rounds_sel = 01 with random state -> out_valid after 8 cycles; result equals ascon_permutation_p8; rounds_sel = 10 -> out_valid after 6 cycles, matching a 6-round golden model (i = 6..11).
- REQ-032: out_ready held low for 20 cycles in DONE -> outputs and out_valid stable throughout; out_ready = 1 -> IDLE next cycle; in_valid pulses during RUN are ignored.
- REQ-033: rst pulsed in cycle 5 of a p12 job -> out_valid never rises; state register is zero; a new job then completes correctly in 12 cycles.
- REQ-034: Back-to-back jobs with in_valid held high -> the second job is accepted one cycle after the DONE handshake, with no result loss.
- REQ-035: ROUNDS_PER_CYCLE = 2 -> p12, p8 and p6 give results identical to ROUNDS_PER_CYCLE = 1, with latencies of 6, 4 and 3 cycles.
